k12a_skip_ctrl: RTL and testbench

Sequencer for the K12A conditional-skip mechanism. Evaluates skip decisions from the ALU condition, then annuls the following 1–4 instructions, counting their words so multi-word instructions are fully suppressed. Sits beside the control unit. The control unit feeds it instruction/word boundary strobes and gates register, memory and PC-jump writes with annul. It also blocks interrupt entry while a skip is in flight.

---
 rtl/k12a_skip_ctrl.sv | 125 ++++++++++++
 tb/tb_k12a_skip_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/k12a_skip_ctrl.sv
// K12A conditional-skip sequencer: arms on a true skip condition, then annuls the
// next 1-4 instructions word by word so multi-word instructions are fully suppressed.
module k12a_skip_ctrl #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 cpu_clock,
  input  logic                 reset_n,
  input  logic                 insn_start,
  input  logic [1:0]           insn_words,
  input  logic                 word_fetch,
  input  logic                 cond_eval,
  input  logic                 cond_invert,
  input  logic                 alu_condition,
  input  logic [1:0]           skip_span,
  input  logic                 flush,
  output logic                 annul,
  output logic                 skip_active,
  output logic                 irq_allow,
  output logic                 protocol_err,
  output logic [CNT_WIDTH-1:0] skipped_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SKIPPING = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] remaining;
  logic [1:0] words_left;

  logic       cond_result;
  logic       violation;
  logic       count_full;
  logic [1:0] extra_words;
  logic [2:0] remaining_dec;

  assign cond_result   = alu_condition ^ cond_invert;
  assign violation     = (state == SKIPPING) && insn_start && (words_left != 2'd0);
  assign count_full    = &skipped_count;
  // A zero word length still means one word, so no extra words follow.
  assign extra_words   = (insn_words == 2'd0) ? 2'd0 : insn_words - 2'd1;
  assign remaining_dec = remaining - 3'd1;

  always_comb begin
    annul = 1'b0;
    case (state)
      ARMED:    annul = insn_start;
      SKIPPING: annul = !violation;
      default:  annul = 1'b0;
    endcase
  end

  assign irq_allow = (state == IDLE) && !cond_eval;

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      remaining     <= 3'd0;
      words_left    <= 2'd0;
      skip_active   <= 1'b0;
      protocol_err  <= 1'b0;
      skipped_count <= '0;
    end else if (flush) begin
      state       <= IDLE;
      remaining   <= 3'd0;
      words_left  <= 2'd0;
      skip_active <= 1'b0;
    end else if (violation) begin
      // A new instruction began before the annulled one finished its words.
      protocol_err <= 1'b1;
      state        <= IDLE;
      remaining    <= 3'd0;
      words_left   <= 2'd0;
      skip_active  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cond_eval && cond_result) begin
            state       <= ARMED;
            remaining   <= {1'b0, skip_span} + 3'd1;
            skip_active <= 1'b1;
          end
        end
        ARMED: begin
          if (insn_start) begin
            if (!count_full) begin
              skipped_count <= skipped_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            words_left <= extra_words;
            if (extra_words != 2'd0) begin
              state <= SKIPPING;
            end else begin
              remaining <= remaining_dec;
              if (remaining_dec == 3'd0) begin
                state       <= IDLE;
                skip_active <= 1'b0;
              end
            end
          end
        end
        SKIPPING: begin
          if (word_fetch) begin
            words_left <= words_left - 2'd1;
            if (words_left == 2'd1) begin
              remaining <= remaining_dec;
              if (remaining_dec == 3'd0) begin
                state       <= IDLE;
                skip_active <= 1'b0;
              end else begin
                state <= ARMED;
              end
            end
          end
        end
        default: begin
          state       <= IDLE;
          skip_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k12a_skip_ctrl.sv
// Scoreboard bench for k12a_skip_ctrl: directed plan scenarios then randomized
// instruction streams, checked against an instruction-count reference model.
module tb_k12a_skip_ctrl;

  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          cpu_clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          insn_start = 1'b0;
  logic [1:0]    insn_words = 2'd0;
  logic          word_fetch = 1'b0;
  logic          cond_eval = 1'b0;
  logic          cond_invert = 1'b0;
  logic          alu_condition = 1'b0;
  logic [1:0]    skip_span = 2'd0;
  logic          flush = 1'b0;
  logic          annul;
  logic          skip_active;
  logic          irq_allow;
  logic          protocol_err;
  logic [CW-1:0] skipped_count;

  k12a_skip_ctrl #(.CNT_WIDTH(CW)) dut (
    .cpu_clock    (cpu_clock),
    .reset_n      (reset_n),
    .insn_start   (insn_start),
    .insn_words   (insn_words),
    .word_fetch   (word_fetch),
    .cond_eval    (cond_eval),
    .cond_invert  (cond_invert),
    .alu_condition(alu_condition),
    .skip_span    (skip_span),
    .flush        (flush),
    .annul        (annul),
    .skip_active  (skip_active),
    .irq_allow    (irq_allow),
    .protocol_err (protocol_err),
    .skipped_count(skipped_count)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct {
    logic annul;
    logic irq_allow;
    logic skip_active;
    logic protocol_err;
    int   count;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model: instructions still to be skipped and words still owed by
  // the instruction currently being annulled.
  int m_skip  = 0;
  int m_words = 0;
  int m_count = 0;
  bit m_err   = 0;
  bit m_active = 0;

  task automatic check(input string name, input int cyc_no, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
  endtask

  task automatic model_reset();
    m_skip = 0; m_words = 0; m_count = 0; m_err = 0; m_active = 0;
  endtask

  task automatic model_step();
    exp_t e;
    bit   r;
    int   len;
    r = alu_condition ^ cond_invert;
    if (m_words > 0)     e.annul = !insn_start;
    else if (m_skip > 0) e.annul = insn_start;
    else                 e.annul = 1'b0;
    e.irq_allow    = (m_skip == 0) && (m_words == 0) && !cond_eval;
    e.skip_active  = m_active;
    e.protocol_err = m_err;
    e.count        = m_count;
    e.cyc          = cyc;
    sb.push_back(e);
    len = (insn_words == 2'd0) ? 1 : int'(insn_words);
    if (flush) begin
      m_skip = 0; m_words = 0;
    end else if (m_words > 0 && insn_start) begin
      m_err = 1; m_skip = 0; m_words = 0;
    end else if (m_words > 0) begin
      if (word_fetch) m_words--;
    end else if (m_skip > 0) begin
      if (insn_start) begin
        m_skip--;
        m_words = len - 1;
        if (m_count < CNT_MAX) m_count++;
      end
    end else if (cond_eval && r) begin
      m_skip = int'(skip_span) + 1;
    end
    m_active = (m_skip > 0) || (m_words > 0);
  endtask

  task automatic drive(input logic is, input logic [1:0] iw, input logic wf, input logic ce,
                       input logic ac, input logic ci, input logic [1:0] sp, input logic fl);
    @(posedge cpu_clock); #1;
    reset_n = 1'b1;
    insn_start = is; insn_words = iw; word_fetch = wf; cond_eval = ce;
    alu_condition = ac; cond_invert = ci; skip_span = sp; flush = fl;
    cyc++;
    model_step();
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge cpu_clock); #1;
    insn_start = 0; insn_words = 0; word_fetch = 0; cond_eval = 0;
    alu_condition = 0; cond_invert = 0; skip_span = 0; flush = 0;
    reset_n = 1'b0;
    cyc++;
    model_reset();
    e.annul = 0; e.irq_allow = 1; e.skip_active = 0; e.protocol_err = 0; e.count = 0; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive(0, 2'd0, 0, 0, 0, 0, 2'd0, 0);
  endtask

  task automatic skip_eval(input logic ac, input logic ci, input logic [1:0] sp);
    drive(0, 2'd0, 0, 1, ac, ci, sp, 0);
  endtask

  task automatic insn(input logic [1:0] w, input int max_stall);
    int len;
    len = (w == 2'd0) ? 1 : int'(w);
    drive(1, w, 1, 0, 0, 0, 2'd0, 0);
    for (int k = 1; k < len; k++) begin
      repeat ($urandom_range(max_stall, 0)) idle();
      drive(0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge cpu_clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("annul",         e.cyc, int'(annul),         int'(e.annul));
        check("irq_allow",     e.cyc, int'(irq_allow),     int'(e.irq_allow));
        check("skip_active",   e.cyc, int'(skip_active),   int'(e.skip_active));
        check("protocol_err",  e.cyc, int'(protocol_err),  int'(e.protocol_err));
        check("skipped_count", e.cyc, int'(skipped_count), e.count);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    idle();

    // Single-instruction skip, then the following instruction commits.
    skip_eval(1, 0, 2'd0);
    insn(2'd1, 0);
    insn(2'd1, 0);
    idle();

    // Inverted condition, two instructions: a 2-word then a 1-word, with stalls.
    skip_eval(0, 1, 2'd1);
    idle();
    insn(2'd2, 2);
    insn(2'd1, 0);
    insn(2'd0, 0);
    idle();

    // Flush while armed with three instructions left.
    skip_eval(1, 0, 2'd2);
    drive(0, 2'd0, 0, 0, 0, 0, 2'd0, 1);
    insn(2'd1, 0);
    insn(2'd1, 0);

    // False condition skips nothing; a skip inside the window does not chain.
    skip_eval(1, 1, 2'd3);
    insn(2'd1, 0);
    skip_eval(1, 0, 2'd1);
    insn(2'd1, 0);
    skip_eval(1, 0, 2'd3);
    insn(2'd1, 0);
    insn(2'd1, 0);
    insn(2'd3, 1);

    // New instruction while two words are still owed: sticky protocol error.
    skip_eval(1, 0, 2'd0);
    drive(1, 2'd3, 1, 0, 0, 0, 2'd0, 0);
    drive(1, 2'd1, 1, 0, 0, 0, 2'd0, 0);
    insn(2'd1, 0);
    skip_eval(1, 0, 2'd0);
    insn(2'd2, 0);

    // Reset in the middle of a multi-word annul with two instructions pending.
    skip_eval(1, 0, 2'd2);
    insn(2'd1, 0);
    drive(1, 2'd2, 1, 0, 0, 0, 2'd0, 0);
    do_reset();
    idle();
    insn(2'd1, 0);

    // Counter saturation.
    for (int n = 0; n < 300; n++) begin
      skip_eval(1, 0, 2'd0);
      insn(2'd1, 0);
    end
    idle();

    // Randomized instruction stream with skips, flushes, stray fetches and rare violations.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [1:0] w;
      int len;
      w = 2'($urandom_range(3, 0));
      len = (w == 2'd0) ? 1 : int'(w);
      drive(1, w, 1, 0, 0, 0, 2'd0, 0);
      if ($urandom_range(99, 0) < 35)
        drive(0, 2'd0, 0, 1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              2'($urandom_range(3, 0)), 0);
      for (int k = 1; k < len; k++) begin
        if ($urandom_range(99, 0) < 2) break;
        repeat ($urandom_range(2, 0))
          drive(0, 2'd0, 0, 0, 0, 0, 2'd0, 1'($urandom_range(99, 0) < 3));
        drive(0, 2'd0, 1, 0, 0, 0, 2'd0, 0);
      end
      if ($urandom_range(99, 0) < 10)
        drive(0, 2'd0, 1'($urandom_range(1, 0)), 0, 0, 0, 2'd0, 1'($urandom_range(99, 0) < 20));
    end
    idle();

    @(negedge cpu_clock); #1;
    check("scoreboard_drained", cyc, sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
